// File: rtl/tatsujin_pkg.sv
// Shared types and constants for the tatsujin note-lane display path.
package tatsujin_pkg;

    localparam int unsigned NUM_SLOTS   = 10;
    localparam int unsigned SQUARE_SIZE = 4;

    localparam logic [2:0] COLOUR_BG   = 3'b000;
    localparam logic [2:0] COLOUR_NOTE = 3'b100;
    localparam logic [2:0] COLOUR_HIT  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } render_state_t;

    // Pick the fill colour of one slot square.
    function automatic logic [2:0] slot_colour(
        input logic       present,
        input logic       judged,
        input logic [2:0] note_c,
        input logic [2:0] hit_c,
        input logic [2:0] bg_c
    );
        if (!present)
            return bg_c;
        return judged ? hit_c : note_c;
    endfunction

endpackage

// File: rtl/note_lane_renderer_if.sv
// Pixel-write bus from the note lane renderer towards the VGA adapter.
interface note_lane_renderer_if;

    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    modport master (
        output x, y, colour, plot, busy, frame_done
    );

    modport slave (
        input x, y, colour, plot, busy, frame_done
    );

endinterface

// File: rtl/note_lane_renderer_sync_edge_pulse.sv
// Two-flop synchroniser followed by a registered rising-edge one-shot.
// A rise on async_in gives a one-cycle pulse three clk edges later.
module sync_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronise the input and register a one-cycle pulse on its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/note_lane_renderer.sv
// Draws the 10-slot note window as ten 4x4 squares on the 160x120 framebuffer,
// one pixel per clk, restarting on each scroll-clock rising edge.
module note_lane_renderer
    import tatsujin_pkg::*;
#(
    parameter int unsigned X_ORIGIN    = 8,
    parameter int unsigned SLOT_PITCH  = 8,
    parameter int unsigned ROW         = 53,
    parameter logic [2:0]  NOTE_COLOUR = COLOUR_NOTE,
    parameter logic [2:0]  HIT_COLOUR  = COLOUR_HIT,
    parameter logic [2:0]  BG_COLOUR   = COLOUR_BG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           notes,
    input  logic                 scroll_clk,
    note_lane_renderer_if.master pix
);

    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [1:0] LAST_SUB  = 2'(SQUARE_SIZE - 1);

    render_state_t state_q, state_n;

    logic       tick;
    logic       pending_q;
    logic [9:0] snap_q;
    logic [3:0] slot_q;
    logic [1:0] col_q;
    logic [1:0] r_q;
    logic       last_pix;

    logic [7:0] pix_x_c;
    logic [6:0] pix_y_c;
    logic [2:0] pix_colour_c;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       plot_q;
    logic       busy_q;
    logic       frame_done_q;

    sync_edge_pulse u_scroll_sync (
        .clk      (clk),
        .rst      (reset),
        .async_in (scroll_clk),
        .pulse    (tick)
    );

    assign last_pix = (slot_q == LAST_SLOT) && (r_q == LAST_SUB) && (col_q == LAST_SUB);

    // Address and colour of the pixel selected by the sweep counters.
    always_comb begin
        pix_x_c      = 8'(X_ORIGIN) + 8'(slot_q * SLOT_PITCH) + {6'b0, col_q};
        pix_y_c      = 7'(ROW) + {5'b0, r_q};
        pix_colour_c = slot_colour(snap_q[slot_q], slot_q == 4'd0,
                                   NOTE_COLOUR, HIT_COLOUR, BG_COLOUR);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Next-state logic; a tick arriving in DONE starts the next sweep directly.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:  if (tick) state_n = LATCH;
            LATCH: state_n = DRAW;
            DRAW:  if (last_pix) state_n = DONE;
            DONE:  state_n = (pending_q || tick) ? LATCH : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One-deep request memory for ticks that arrive while a sweep is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending_q <= 1'b0;
        else if (state_q == DONE)
            pending_q <= 1'b0;
        else if (tick && state_q != IDLE)
            pending_q <= 1'b1;
    end

    // Snapshot capture and sweep counters: col fastest, then row, then slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
            slot_q <= '0;
            col_q  <= '0;
            r_q    <= '0;
        end else if (state_q == LATCH) begin
            snap_q <= notes;
            slot_q <= '0;
            col_q  <= '0;
            r_q    <= '0;
        end else if (state_q == DRAW) begin
            col_q <= col_q + 2'd1;
            if (col_q == LAST_SUB) begin
                r_q <= r_q + 2'd1;
                if (r_q == LAST_SUB)
                    slot_q <= last_pix ? 4'd0 : slot_q + 4'd1;
            end
        end
    end

    // Registered pixel outputs. They trail the DRAW state by one clk, so busy is
    // raised on entry to LATCH and dropped on leaving DONE to cover the whole
    // frame including the trailing pixel; frame_done follows the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= BG_COLOUR;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            plot_q       <= (state_q == DRAW);
            frame_done_q <= (state_q == DONE);
            busy_q       <= (state_n != IDLE);
            if (state_q == DRAW) begin
                x_q      <= pix_x_c;
                y_q      <= pix_y_c;
                colour_q <= pix_colour_c;
            end
        end
    end

    assign pix.x          = x_q;
    assign pix.y          = y_q;
    assign pix.colour     = colour_q;
    assign pix.plot       = plot_q;
    assign pix.busy       = busy_q;
    assign pix.frame_done = frame_done_q;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Directed bench for note_lane_renderer with a per-pixel scoreboard.
module tb_note_lane_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] notes = '0;
    logic       scroll_clk = 1'b0;

    note_lane_renderer_if pix_bus ();

    note_lane_renderer #(
        .X_ORIGIN   (8),
        .SLOT_PITCH (8),
        .ROW        (53)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .notes      (notes),
        .scroll_clk (scroll_clk),
        .pix        (pix_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [9:0] snap_q[$];
    logic [9:0] cur_snap = '0;
    int cyc = 0;
    int sweep_idx = 0;
    int pix_err = 0;
    int total_plots = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int start_gap = 0;
    int busy_run = 0;
    int last_busy_run = 0;
    int first_x = 0, first_y = 0, last_x = 0, last_y = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            sweep_idx = 0;
            pix_err   = 0;
            busy_run  = 0;
            snap_q.delete();
        end else begin
            if (pix_bus.plot) begin
                int s, r, c, ex, ey, ec;
                if (sweep_idx == 0) begin
                    start_gap = cyc - fd_cyc;
                    first_x = pix_bus.x;
                    first_y = pix_bus.y;
                    if (snap_q.size() == 0) begin
                        pix_err++;
                        cur_snap = '0;
                    end else begin
                        cur_snap = snap_q.pop_front();
                    end
                end
                s  = sweep_idx / 16;
                r  = (sweep_idx % 16) / 4;
                c  = sweep_idx % 4;
                ex = 8 + s * 8 + c;
                ey = 53 + r;
                ec = (s < 10 && cur_snap[s]) ? ((s == 0) ? 2 : 4) : 0;
                if (pix_bus.x != 8'(ex) || pix_bus.y != 7'(ey) || pix_bus.colour != 3'(ec))
                    pix_err++;
                last_x = pix_bus.x;
                last_y = pix_bus.y;
                sweep_idx++;
                total_plots++;
            end
            if (pix_bus.frame_done) begin
                check_val("sweep_pixels", pix_err, 0);
                check_val("sweep_len", sweep_idx, 160);
                sweep_idx = 0;
                pix_err   = 0;
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (pix_bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic scroll_rise();
        @(negedge clk) scroll_clk = 1'b1;
        repeat (8) @(negedge clk);
        scroll_clk = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (sweep_idx < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_val("wait_idx_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < 3000) begin
            @(negedge clk);
            if (pix_bus.busy) quiet = 0;
            else quiet++;
            n++;
        end
        if (quiet < 10) check_val("idle_timeout", 1, 0);
    endtask

    int p0, f0;

    initial begin
        // 1: reset values, then reset in the middle of DRAW.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_x", pix_bus.x, 0);
        check_val("rst_y", pix_bus.y, 0);
        check_val("rst_colour", pix_bus.colour, 0);
        check_val("rst_plot", pix_bus.plot, 0);
        check_val("rst_busy", pix_bus.busy, 0);
        check_val("rst_fd", pix_bus.frame_done, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        notes = 10'h3FF;
        snap_q.push_back(10'h3FF);
        scroll_rise();
        wait_idx(40);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_plot", pix_bus.plot, 0);
        check_val("midrst_busy", pix_bus.busy, 0);
        check_val("midrst_x", pix_bus.x, 0);
        check_val("midrst_y", pix_bus.y, 0);
        check_val("midrst_colour", pix_bus.colour, 0);
        check_val("midrst_fd", pix_bus.frame_done, 0);
        scroll_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        p0 = total_plots;
        f0 = fd_cnt;
        repeat (300) @(negedge clk);
        check_val("post_rst_plots", total_plots - p0, 0);
        check_val("post_rst_fd", fd_cnt - f0, 0);

        // 2: only the judged slot holds a note.
        notes = 10'b0000000001;
        snap_q.push_back(10'b0000000001);
        p0 = total_plots; f0 = fd_cnt;
        scroll_rise();
        wait_idle();
        check_val("t2_plots", total_plots - p0, 160);
        check_val("t2_fd", fd_cnt - f0, 1);
        check_val("t2_first_x", first_x, 8);
        check_val("t2_first_y", first_y, 53);
        check_val("t2_busy_len", last_busy_run, 162);

        // 3: only the far slot holds a note.
        notes = 10'b1000000000;
        snap_q.push_back(10'b1000000000);
        p0 = total_plots; f0 = fd_cnt;
        scroll_rise();
        wait_idle();
        check_val("t3_plots", total_plots - p0, 160);
        check_val("t3_last_x", last_x, 83);
        check_val("t3_last_y", last_y, 56);

        // 4: notes drop to zero mid-sweep; only the next sweep sees it.
        notes = 10'h3FF;
        snap_q.push_back(10'h3FF);
        snap_q.push_back(10'h000);
        p0 = total_plots; f0 = fd_cnt;
        scroll_rise();
        wait_idx(50);
        notes = 10'h000;
        wait_idle();
        scroll_rise();
        wait_idle();
        check_val("t4_plots", total_plots - p0, 320);
        check_val("t4_fd", fd_cnt - f0, 2);
        check_val("t4_queue", snap_q.size(), 0);

        // 5: three extra rises during one sweep coalesce into one follow-up sweep.
        notes = 10'h155;
        snap_q.push_back(10'h155);
        snap_q.push_back(10'h155);
        p0 = total_plots; f0 = fd_cnt;
        scroll_rise();
        wait_idx(20);
        scroll_rise();
        wait_idx(60);
        scroll_rise();
        wait_idx(100);
        scroll_rise();
        wait_idle();
        check_val("t5_plots", total_plots - p0, 320);
        check_val("t5_fd", fd_cnt - f0, 2);
        check_val("t5_gap", start_gap, 2);
        check_val("t5_queue", snap_q.size(), 0);

        // 6: free-running 50% duty scroll clock, one sweep per rise.
        notes = 10'h0AA;
        for (int k = 0; k < 4; k++) snap_q.push_back(10'h0AA);
        p0 = total_plots; f0 = fd_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) scroll_clk = 1'b1;
            repeat (200) @(negedge clk);
            scroll_clk = 1'b0;
            repeat (200) @(negedge clk);
        end
        wait_idle();
        check_val("t6_plots", total_plots - p0, 640);
        check_val("t6_fd", fd_cnt - f0, 4);
        check_val("t6_busy_len", last_busy_run, 162);
        check_val("t6_queue", snap_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
